// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared types and constants for the data bus router
package data_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT0 = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RAM_MASK  = 32'hF000_0000;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_MMIO_MASK = 32'hF000_0000;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - saturating response-wait counter
module bus_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th wait cycle, i.e. the cycle whose increment reaches TIMEOUT.
  assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/data_bus_router.sv
// rtl/data_bus_router.sv - steers core data requests to RAM or MMIO and returns one response
module data_bus_router
  import data_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
  parameter logic [31:0] RAM_MASK  = DEFAULT_RAM_MASK,
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK = DEFAULT_MMIO_MASK,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req_valid,
  output logic        up_req_ready,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  input  logic        up_we,
  input  logic [3:0]  up_wstrb,
  output logic        up_rsp_valid,
  output logic [31:0] up_rdata,
  output logic        up_rsp_err,
  output logic        t0_req_valid,
  input  logic        t0_req_ready,
  output logic [31:0] t0_addr,
  output logic [31:0] t0_wdata,
  output logic        t0_we,
  output logic [3:0]  t0_wstrb,
  input  logic        t0_rsp_valid,
  input  logic [31:0] t0_rdata,
  output logic        t1_req_valid,
  input  logic        t1_req_ready,
  output logic [31:0] t1_addr,
  output logic [31:0] t1_wdata,
  output logic        t1_we,
  output logic [3:0]  t1_wstrb,
  input  logic        t1_rsp_valid,
  input  logic [31:0] t1_rdata
);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        sel0, sel1, sel_none;
  logic        ctr_clr, ctr_en, expired;

  assign sel0     = (up_addr & RAM_MASK) == RAM_BASE;
  assign sel1     = !sel0 && ((up_addr & MMIO_MASK) == MMIO_BASE);
  assign sel_none = !sel0 && !sel1;

  assign t0_addr  = up_addr;
  assign t0_wdata = up_wdata;
  assign t0_we    = up_we;
  assign t0_wstrb = up_wstrb;
  assign t1_addr  = up_addr;
  assign t1_wdata = up_wdata;
  assign t1_we    = up_we;
  assign t1_wstrb = up_wstrb;

  assign ctr_en = (state_q == ST_WAIT0) || (state_q == ST_WAIT1);

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    we_d         = we_q;
    t0_req_valid = 1'b0;
    t1_req_valid = 1'b0;
    up_req_ready = 1'b0;
    ctr_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while rst is asserted so every output sits at its reset value.
        if (!rst) begin
          t0_req_valid = up_req_valid && sel0;
          t1_req_valid = up_req_valid && sel1;
          up_req_ready = (sel0 && t0_req_ready) || (sel1 && t1_req_ready) || sel_none;
        end
        if (up_req_valid && up_req_ready) begin
          ctr_clr = 1'b1;
          we_d    = up_we;
          if (sel0) begin
            state_d = ST_WAIT0;
          end else if (sel1) begin
            state_d = ST_WAIT1;
          end else begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = RSP_ERR;
          end
        end
      end
      ST_WAIT0, ST_WAIT1: begin
        // A response in the expiry cycle still counts as a success.
        if ((state_q == ST_WAIT0) ? t0_rsp_valid : t1_rsp_valid) begin
          rdata_d = we_q ? 32'h0 : ((state_q == ST_WAIT0) ? t0_rdata : t1_rdata);
          err_d   = RSP_OK;
          state_d = ST_RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = RSP_ERR;
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= RSP_OK;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  assign up_rsp_valid = (state_q == ST_RESP);
  assign up_rdata     = up_rsp_valid ? rdata_q : 32'h0;
  assign up_rsp_err   = up_rsp_valid && err_q;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

endmodule

// File: tb/tb_data_bus_router.sv
// tb/tb_data_bus_router.sv - directed vector bench for data_bus_router
module tb_data_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req_valid, up_req_ready, up_we;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic [3:0]  up_wstrb;
  logic        up_rsp_valid, up_rsp_err;
  logic        t0_req_valid, t0_req_ready, t0_we, t0_rsp_valid;
  logic [31:0] t0_addr, t0_wdata, t0_rdata;
  logic [3:0]  t0_wstrb;
  logic        t1_req_valid, t1_req_ready, t1_we, t1_rsp_valid;
  logic [31:0] t1_addr, t1_wdata, t1_rdata;
  logic [3:0]  t1_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_bus_router #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_addr(up_addr),
    .up_wdata(up_wdata), .up_we(up_we), .up_wstrb(up_wstrb),
    .up_rsp_valid(up_rsp_valid), .up_rdata(up_rdata), .up_rsp_err(up_rsp_err),
    .t0_req_valid(t0_req_valid), .t0_req_ready(t0_req_ready), .t0_addr(t0_addr),
    .t0_wdata(t0_wdata), .t0_we(t0_we), .t0_wstrb(t0_wstrb),
    .t0_rsp_valid(t0_rsp_valid), .t0_rdata(t0_rdata),
    .t1_req_valid(t1_req_valid), .t1_req_ready(t1_req_ready), .t1_addr(t1_addr),
    .t1_wdata(t1_wdata), .t1_we(t1_we), .t1_wstrb(t1_wstrb),
    .t1_rsp_valid(t1_rsp_valid), .t1_rdata(t1_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          tgt;     // 0 = RAM, 1 = MMIO, 2 = undecoded
    int          k;       // target response delay after accept, 0 = never
    logic [31:0] trdata;
    int          lat;     // expected cycles from accept to up_rsp_valid
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_req_valid = 1'b0; up_addr = 32'h0; up_wdata = 32'h0; up_we = 1'b0; up_wstrb = 4'h0;
    t0_req_ready = 1'b0; t1_req_ready = 1'b0;
    t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0; t0_rdata = 32'h0; t1_rdata = 32'h0;
  endtask

  task automatic no_rsp_for(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {31'b0, up_rsp_valid}, 32'h0);
      step();
    end
  endtask

  task automatic txn(input vec_t v, input string tag);
    int lat = 0;
    up_req_valid = 1'b1; up_addr = v.addr; up_we = v.we; up_wstrb = v.wstrb; up_wdata = v.wdata;
    t0_req_ready = 1'b1; t1_req_ready = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, {31'b0, up_req_ready}, 32'h1);
    check({tag, ".t0v"}, {31'b0, t0_req_valid}, {31'b0, v.tgt == 0});
    check({tag, ".t1v"}, {31'b0, t1_req_valid}, {31'b0, v.tgt == 1});
    check({tag, ".fwd_addr"}, (v.tgt == 1) ? t1_addr : t0_addr, v.addr);
    check({tag, ".fwd_strb"}, {28'b0, t1_wstrb}, {28'b0, v.wstrb});
    step();
    up_req_valid = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      t0_rsp_valid = (v.tgt == 0) && (c == v.k);
      t1_rsp_valid = (v.tgt == 1) && (c == v.k);
      t0_rdata = v.trdata; t1_rdata = v.trdata;
      @(negedge clk);
      check({tag, ".no_req"}, {30'b0, t0_req_valid, t1_req_valid}, 32'h0);
      if (up_rsp_valid) begin
        lat = c;
        check({tag, ".rdata"}, up_rdata, v.rdata);
        check({tag, ".err"}, {31'b0, up_rsp_err}, {31'b0, v.err});
      end
      step();
    end
    t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(v.lat));
    @(negedge clk);
    check({tag, ".pulse"}, {31'b0, up_rsp_valid}, 32'h0);
    step();
  endtask

  initial begin
    int hs_n, rsp_n, hs_first, hs_second;
    vecs[0] = '{32'h0000_0040, 1'b0, 4'hF, 32'h0,          0, 2,  32'hDEAD_BEEF, 3,  1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0100, 1'b1, 4'hF, 32'h5555_AAAA, 0, 1,  32'h1234_5678, 2,  1'b0, 32'h0};
    vecs[2] = '{32'h1000_0008, 1'b0, 4'hF, 32'h0,          1, 4,  32'hCAFE_F00D, 5,  1'b0, 32'hCAFE_F00D};
    vecs[3] = '{32'h2000_0000, 1'b0, 4'hF, 32'h0,          2, 0,  32'h0,         1,  1'b1, 32'h0};
    vecs[4] = '{32'hF000_0010, 1'b1, 4'h1, 32'h0000_00FF, 2, 0,  32'h0,         1,  1'b1, 32'h0};
    vecs[5] = '{32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0,          0, 0,  32'h0,         17, 1'b1, 32'h0};
    vecs[6] = '{32'h1000_0000, 1'b1, 4'hC, 32'h0BAD_0000, 1, 0,  32'h0,         17, 1'b1, 32'h0};
    vecs[7] = '{32'h0000_0080, 1'b0, 4'hF, 32'h0,          0, 16, 32'hA5A5_5A5A, 17, 1'b0, 32'hA5A5_5A5A};

    idle_inputs();
    rst = 1'b1;
    up_req_valid = 1'b1; up_addr = 32'h0000_0040; t0_req_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst.ready", {31'b0, up_req_ready}, 32'h0);
    check("rst.t0v", {31'b0, t0_req_valid}, 32'h0);
    check("rst.rsp", {30'b0, up_rsp_valid, up_rsp_err}, 32'h0);
    check("rst.rdata", up_rdata, 32'h0);
    step();
    idle_inputs();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i], $sformatf("vec%0d", i));
    end

    // late response after a timeout is dropped
    txn(vecs[5], "late");
    step();
    t0_rsp_valid = 1'b1; t0_rdata = 32'h7777_7777;
    step();
    t0_rsp_valid = 1'b0;
    no_rsp_for("late.ignored", 3);

    // MMIO write with target backpressure
    up_req_valid = 1'b1; up_addr = 32'h1000_0004; up_we = 1'b1; up_wstrb = 4'b0011;
    up_wdata = 32'h0000_BEEF; t1_req_ready = 1'b0; t0_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.ready_low", {31'b0, up_req_ready}, 32'h0);
      check("bp.t1v", {30'b0, t0_req_valid, t1_req_valid}, 32'h1);
      step();
    end
    t1_req_ready = 1'b1;
    @(negedge clk);
    check("bp.ready_high", {31'b0, up_req_ready}, 32'h1);
    check("bp.wstrb", {28'b0, t1_wstrb}, 32'h3);
    step();
    up_req_valid = 1'b0; t1_rsp_valid = 1'b1; t1_rdata = 32'hFFFF_FFFF;
    step();
    t1_rsp_valid = 1'b0;
    @(negedge clk);
    check("bp.rsp", {30'b0, up_rsp_valid, up_rsp_err}, 32'h2);
    check("bp.rdata", up_rdata, 32'h0);
    step();

    // reset while waiting on MMIO
    up_req_valid = 1'b1; up_addr = 32'h1000_0010; up_we = 1'b0; t1_req_ready = 1'b1;
    step();
    up_req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; t0_req_ready = 1'b0; t1_req_ready = 1'b0;
    @(negedge clk);
    check("mrst.outs", {28'b0, up_req_ready, up_rsp_valid, t0_req_valid, t1_req_valid}, 32'h0);
    check("mrst.rdata", {up_rdata[30:0], up_rsp_err}, 32'h0);
    step();
    t1_rsp_valid = 1'b1; t1_rdata = 32'h4444_4444;
    step();
    t1_rsp_valid = 1'b0;
    no_rsp_for("mrst.ignored", 3);
    txn(vecs[0], "mrst.after");

    // back-to-back reads with the RAM answering immediately
    hs_n = 0; rsp_n = 0; hs_first = -1; hs_second = -1;
    up_req_valid = 1'b1; up_addr = 32'h0000_0200; up_we = 1'b0; up_wstrb = 4'hF;
    t0_req_ready = 1'b1; t0_rsp_valid = 1'b1; t0_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (up_req_valid && up_req_ready) begin
        if (hs_n == 0) hs_first = c;
        else if (hs_n == 1) hs_second = c;
        hs_n++;
      end
      if (up_rsp_valid) begin
        rsp_n++;
        check("b2b.rdata", up_rdata, 32'h0BAD_F00D);
      end
      step();
    end
    idle_inputs();
    check("b2b.accepts", 32'(hs_n), 32'd3);
    check("b2b.gap", 32'(hs_second - hs_first), 32'd3);
    check("b2b.rsps", 32'(rsp_n), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
